// File: rtl/update_player_arc.sv
// Player updater: jump arc (rise/apex/fall) with duck. Each clk3 edge is one game tick.
// Optional fast-fall while ducking in the air: define UPDATE_PLAYER_FAST_FALL_EN.

// Object-record field layout shared with collision/render; only defined here if not already supplied.
`ifndef PL_DATALEN
`define PL_DATALEN     40
`define PL_TYPEFIELD   39:36
`define PL_XFIELD      35:26
`define PL_YFIELD      25:16
`define PL_WIDTHFIELD  15:8
`define PL_HEIGHTFIELD 7:0
`define PL_PLAYERTYPE  4'd1
`define playerxPos     10'd40
`define PL_PLAYERWIDTH 8'd16
`endif

module update_player_arc #(
  parameter int GROUND_Y      = 100,
  parameter int JUMP_HEIGHT   = 40,
  parameter int RISE_STEP     = 10,
  parameter int FALL_STEP     = 8,
  parameter int APEX_TICKS    = 3,
  parameter int PLAYER_HEIGHT = 20,
  parameter int DUCK_HEIGHT   = 12
) (
  input  logic                   clk3,
  input  logic                   reset,
  input  logic                   pause,
  input  logic                   jump,
  input  logic                   duck,
  output logic [`PL_DATALEN-1:0] player,
  output logic                   airborne,
  output logic                   landed
);

`ifdef UPDATE_PLAYER_FAST_FALL_EN
  localparam bit FAST_FALL = 1'b1;
`else
  localparam bit FAST_FALL = 1'b0;
`endif

  localparam logic [10:0] GROUND_Y11 = 11'(GROUND_Y);
  localparam logic [10:0] APEX_Y11   = 11'(GROUND_Y - JUMP_HEIGHT);
  localparam logic [10:0] RISE11     = 11'(RISE_STEP);
  localparam logic [10:0] FALL11     = 11'(FALL_STEP);
  localparam logic [10:0] FALL2_11   = 11'(2 * FALL_STEP);
  localparam logic [9:0]  GROUND_Y10 = 10'(GROUND_Y);
  localparam logic [9:0]  APEX_Y10   = 10'(GROUND_Y - JUMP_HEIGHT);
  localparam logic [9:0]  DUCK_Y10   = 10'(GROUND_Y + PLAYER_HEIGHT - DUCK_HEIGHT);
  localparam logic [7:0]  PLAYER_H8  = 8'(PLAYER_HEIGHT);
  localparam logic [7:0]  DUCK_H8    = 8'(DUCK_HEIGHT);
  localparam logic [8:0]  APEX_T9    = 9'(APEX_TICKS);

  typedef enum logic [2:0] {
    ST_GROUND = 3'd0,
    ST_DUCK   = 3'd1,
    ST_RISE   = 3'd2,
    ST_APEX   = 3'd3,
    ST_FALL   = 3'd4
  } state_t;

  logic   jump_s1_q, jump_s2_q, jp_prev_q;
  logic   duck_s1_q, duck_s2_q;
  state_t state_q, state_d;
  logic [9:0] y_q, y_d;
  logic [7:0] height_q, height_d;
  logic [7:0] cnt_q, cnt_d;
  logic       airborne_q, airborne_d;
  logic       landed_q, landed_d;

  logic        jump_edge, duck_held, fast_duck;
  logic [10:0] rise_y, fall_y;
  logic        rise_at_apex, fall_at_ground;
  logic [8:0]  cnt_inc;

  always_comb begin
    jump_edge = !jump_s2_q && jp_prev_q;
    duck_held = !duck_s2_q;
    fast_duck = FAST_FALL && duck_held;

    // One extra bit: bit 10 set means the rise step went above screen top.
    rise_y         = {1'b0, y_q} - RISE11;
    rise_at_apex   = rise_y[10] || (rise_y <= APEX_Y11);
    fall_y         = {1'b0, y_q} + (fast_duck ? FALL2_11 : FALL11);
    fall_at_ground = fall_y >= GROUND_Y11;
    cnt_inc        = {1'b0, cnt_q} + 9'd1;

    state_d  = state_q;
    y_d      = y_q;
    height_d = height_q;
    cnt_d    = cnt_q;
    landed_d = 1'b0;

    if (!pause) begin
      case (state_q)
        ST_GROUND: begin
          if (duck_held) begin
            state_d  = ST_DUCK;
            height_d = DUCK_H8;
            y_d      = DUCK_Y10;
          end else if (jump_edge) begin
            if (rise_at_apex) begin
              state_d = ST_APEX;
              y_d     = APEX_Y10;
              cnt_d   = 8'd0;
            end else begin
              state_d = ST_RISE;
              y_d     = rise_y[9:0];
            end
          end
        end
        ST_DUCK: begin
          if (!duck_held) begin
            state_d  = ST_GROUND;
            height_d = PLAYER_H8;
            y_d      = GROUND_Y10;
          end
        end
        ST_RISE: begin
          if (fast_duck) begin
            state_d = ST_FALL;
          end else if (rise_at_apex) begin
            state_d = ST_APEX;
            y_d     = APEX_Y10;
            cnt_d   = 8'd0;
          end else begin
            y_d = rise_y[9:0];
          end
        end
        ST_APEX: begin
          if (fast_duck) begin
            state_d = ST_FALL;
          end else if (cnt_inc >= APEX_T9) begin
            // Last apex tick: the first fall step happens on the same edge.
            cnt_d = 8'd0;
            if (fall_at_ground) begin
              state_d  = ST_GROUND;
              y_d      = GROUND_Y10;
              landed_d = 1'b1;
            end else begin
              state_d = ST_FALL;
              y_d     = fall_y[9:0];
            end
          end else begin
            cnt_d = cnt_inc[7:0];
          end
        end
        ST_FALL: begin
          if (fall_at_ground) begin
            state_d  = ST_GROUND;
            y_d      = GROUND_Y10;
            landed_d = 1'b1;
          end else begin
            y_d = fall_y[9:0];
          end
        end
        default: begin
          state_d  = ST_GROUND;
          y_d      = GROUND_Y10;
          height_d = PLAYER_H8;
          cnt_d    = 8'd0;
        end
      endcase
    end

    airborne_d = (state_d == ST_RISE) || (state_d == ST_APEX) || (state_d == ST_FALL);
  end

  // Synchronisers keep running through pause, so edges seen while paused are consumed.
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      jump_s1_q  <= 1'b1;
      jump_s2_q  <= 1'b1;
      jp_prev_q  <= 1'b1;
      duck_s1_q  <= 1'b1;
      duck_s2_q  <= 1'b1;
      state_q    <= ST_GROUND;
      y_q        <= GROUND_Y10;
      height_q   <= PLAYER_H8;
      cnt_q      <= 8'd0;
      airborne_q <= 1'b0;
      landed_q   <= 1'b0;
    end else begin
      jump_s1_q  <= jump;
      jump_s2_q  <= jump_s1_q;
      jp_prev_q  <= jump_s2_q;
      duck_s1_q  <= duck;
      duck_s2_q  <= duck_s1_q;
      state_q    <= state_d;
      y_q        <= y_d;
      height_q   <= height_d;
      cnt_q      <= cnt_d;
      airborne_q <= airborne_d;
      landed_q   <= landed_d;
    end
  end

  always_comb begin
    player                  = '0;
    player[`PL_TYPEFIELD]   = `PL_PLAYERTYPE;
    player[`PL_XFIELD]      = `playerxPos;
    player[`PL_YFIELD]      = y_q;
    player[`PL_WIDTHFIELD]  = `PL_PLAYERWIDTH;
    player[`PL_HEIGHTFIELD] = height_q;
  end

  assign airborne = airborne_q;
  assign landed   = landed_q;

endmodule

// File: tb/tb_update_player_arc.sv
// Bench for update_player_arc: directed scenarios plus random button traffic vs a tick-level model.

`ifndef PL_DATALEN
`define PL_DATALEN     40
`define PL_TYPEFIELD   39:36
`define PL_XFIELD      35:26
`define PL_YFIELD      25:16
`define PL_WIDTHFIELD  15:8
`define PL_HEIGHTFIELD 7:0
`define PL_PLAYERTYPE  4'd1
`define playerxPos     10'd40
`define PL_PLAYERWIDTH 8'd16
`endif

module tb_update_player_arc;
  localparam int G    = 100;
  localparam int APX  = 60;
  localparam int RS   = 10;
  localparam int FS   = 8;
  localparam int AT   = 3;
  localparam int PH   = 20;
  localparam int DH   = 12;
`ifdef UPDATE_PLAYER_FAST_FALL_EN
  localparam bit FF = 1'b1;
`else
  localparam bit FF = 1'b0;
`endif
  localparam int P_GROUND = 0, P_DUCK = 1, P_RISE = 2, P_APEX = 3, P_FALL = 4;

  logic clk3, reset, pause, jump, duck;
  logic [`PL_DATALEN-1:0] player;
  logic airborne, landed;

  update_player_arc dut (
    .clk3(clk3), .reset(reset), .pause(pause), .jump(jump), .duck(duck),
    .player(player), .airborne(airborne), .landed(landed)
  );

  initial clk3 = 1'b0;
  always #5 clk3 = ~clk3;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: button histories (index 0 = value seen at the latest edge) and the motion phase.
  bit jh[3];
  bit dh[3];
  int m_phase, m_y, m_h, m_seen;
  bit m_air, m_land;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      jh[i] = 1'b1;
      dh[i] = 1'b1;
    end
    m_phase = P_GROUND; m_y = G; m_h = PH; m_seen = 0; m_air = 0; m_land = 0;
  endtask

  task automatic model_fall(input bit dheld);
    int ny;
    ny = m_y + ((FF && dheld) ? 2 * FS : FS);
    if (ny >= G) begin
      m_y = G; m_phase = P_GROUND; m_land = 1;
    end else begin
      m_y = ny; m_phase = P_FALL;
    end
  endtask

  task automatic model_rise();
    int ny;
    ny = m_y - RS;
    if (ny <= APX) begin
      m_y = APX; m_phase = P_APEX; m_seen = 1;
    end else begin
      m_y = ny; m_phase = P_RISE;
    end
  endtask

  // One game tick: a jump counts if it was pressed two ticks ago and released three ticks ago.
  task automatic model_edge();
    bit jedge, dheld;
    jedge  = !jh[1] && jh[2];
    dheld  = !dh[1];
    m_land = 0;
    if (!pause) begin
      case (m_phase)
        P_GROUND: if (dheld) begin
                    m_phase = P_DUCK; m_h = DH; m_y = G + PH - DH;
                  end else if (jedge) model_rise();
        P_DUCK:   if (!dheld) begin
                    m_phase = P_GROUND; m_h = PH; m_y = G;
                  end
        P_RISE:   if (FF && dheld) m_phase = P_FALL; else model_rise();
        P_APEX:   if (FF && dheld) m_phase = P_FALL;
                  else if (m_seen >= AT) model_fall(dheld);
                  else m_seen++;
        default:  model_fall(dheld);
      endcase
    end
    m_air = (m_phase == P_RISE) || (m_phase == P_APEX) || (m_phase == P_FALL);
    jh[2] = jh[1]; jh[1] = jh[0]; jh[0] = jump;
    dh[2] = dh[1]; dh[1] = dh[0]; dh[0] = duck;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_y"}, 32'(player[`PL_YFIELD]), 32'(m_y));
    chk({tag, "_height"}, 32'(player[`PL_HEIGHTFIELD]), 32'(m_h));
    chk({tag, "_airborne"}, 32'(airborne), 32'(m_air));
    chk({tag, "_landed"}, 32'(landed), 32'(m_land));
  endtask

  task automatic tick(input string tag);
    @(posedge clk3);
    model_edge();
    @(negedge clk3);
    check_all(tag);
  endtask

  int  exp_seq[11];
  bit  found;

  initial begin
    exp_seq = '{90, 80, 70, 60, 60, 60, 68, 76, 84, 92, 100};
    reset = 1'b0; pause = 1'b0; jump = 1'b1; duck = 1'b1;
    model_reset();
    #12;
    chk("rst_y", 32'(player[`PL_YFIELD]), 32'(G));
    chk("rst_height", 32'(player[`PL_HEIGHTFIELD]), 32'(PH));
    chk("rst_type", 32'(player[`PL_TYPEFIELD]), 32'(`PL_PLAYERTYPE));
    chk("rst_x", 32'(player[`PL_XFIELD]), 32'(`playerxPos));
    chk("rst_width", 32'(player[`PL_WIDTHFIELD]), 32'(`PL_PLAYERWIDTH));
    chk("rst_airborne", 32'(airborne), 32'd0);
    chk("rst_landed", 32'(landed), 32'd0);

    @(negedge clk3);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) tick("idle");
    chk("idle_y", 32'(player[`PL_YFIELD]), 32'd100);

    // Full arc: jump held five ticks.
    jump = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 6) jump = 1'b1;
      tick("arc");
      if (i >= 3 && i <= 13) begin
        chk("arc_seq_y", 32'(player[`PL_YFIELD]), 32'(exp_seq[i-3]));
        chk("arc_seq_landed", 32'(landed), (i == 13) ? 32'd1 : 32'd0);
      end
    end

    // Duck on ground; jump while ducking is ignored.
    duck = 1'b0;
    for (int i = 0; i < 3; i++) tick("duck");
    chk("duck_height", 32'(player[`PL_HEIGHTFIELD]), 32'd12);
    chk("duck_y", 32'(player[`PL_YFIELD]), 32'd108);
    jump = 1'b0; tick("duck_jmp"); jump = 1'b1;
    for (int i = 0; i < 4; i++) tick("duck_jmp");
    chk("duck_jump_ignored_y", 32'(player[`PL_YFIELD]), 32'd108);
    duck = 1'b1;
    for (int i = 0; i < 3; i++) tick("unduck");
    chk("unduck_height", 32'(player[`PL_HEIGHTFIELD]), 32'd20);
    chk("unduck_y", 32'(player[`PL_YFIELD]), 32'd100);

    // Pause mid-rise with a press inside the pause window.
    jump = 1'b0; tick("p_start"); jump = 1'b1;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick("p_rise");
      if (m_y == 80) found = 1;
    end
    chk("pause_reach80", 32'(found), 32'd1);
    pause = 1'b1;
    tick("pause"); tick("pause");
    jump = 1'b0; tick("pause"); jump = 1'b1;
    tick("pause"); tick("pause"); tick("pause");
    chk("pause_hold_y", 32'(player[`PL_YFIELD]), 32'd80);
    pause = 1'b0;
    tick("unpause");
    chk("unpause_y70", 32'(player[`PL_YFIELD]), 32'd70);
    tick("unpause");
    chk("unpause_y60", 32'(player[`PL_YFIELD]), 32'd60);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick("p_land");
      if (m_phase == P_GROUND) found = 1;
    end
    chk("pause_landed", 32'(found), 32'd1);
    for (int i = 0; i < 4; i++) tick("p_idle");
    chk("pause_no_retrigger_y", 32'(player[`PL_YFIELD]), 32'd100);

    // Asynchronous reset during the fall.
    jump = 1'b0; tick("r_start"); jump = 1'b1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick("r_fall");
      if (m_phase == P_FALL && m_y == 84) found = 1;
    end
    chk("reset_reach84", 32'(found), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("areset_y", 32'(player[`PL_YFIELD]), 32'd100);
    chk("areset_airborne", 32'(airborne), 32'd0);
    chk("areset_landed", 32'(landed), 32'd0);
    model_reset();
    @(negedge clk3);
    chk("areset_hold_landed", 32'(landed), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick("post_rst");

    // Random button traffic.
    for (int i = 0; i < 1500; i++) begin
      jump  = ($urandom_range(0, 3) != 0);
      duck  = ($urandom_range(0, 9) != 0);
      pause = ($urandom_range(0, 11) == 0);
      tick("rand");
    end
    chk("end_type", 32'(player[`PL_TYPEFIELD]), 32'(`PL_PLAYERTYPE));
    chk("end_x", 32'(player[`PL_XFIELD]), 32'(`playerxPos));
    chk("end_width", 32'(player[`PL_WIDTHFIELD]), 32'(`PL_PLAYERWIDTH));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
